// File: rtl/hazard_unit_pkg.sv
// Shared hazard-unit definitions: forward-select codes, the "never used" Tuse value
// and the default multiply/divide latencies.
package hazard_unit_pkg;

    localparam int REG_W        = 5;
    localparam int TW_DEF       = 3;
    localparam int TUSE_NONE    = 7;
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef logic [REG_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the 5-stage datapath (master) and the hazard unit (slave): the ID operand
// tuple, MD/flush events in, stall and forward selects out.
interface hazard_unit_if #(
    parameter int TW = hazard_unit_pkg::TW_DEF
);

    hazard_unit_pkg::reg_addr_t id_raddr0;
    hazard_unit_pkg::reg_addr_t id_raddr1;
    hazard_unit_pkg::reg_addr_t id_waddr;
    logic [TW-1:0]              id_tuse0;
    logic [TW-1:0]              id_tuse1;
    logic [TW-1:0]              id_tnew;
    logic                       id_uses_md;
    logic                       e_md_start;
    logic                       e_md_div;
    logic                       flush;

    logic                       stall;
    logic [1:0]                 fwd_id_rs;
    logic [1:0]                 fwd_id_rt;
    logic [1:0]                 fwd_e_rs;
    logic [1:0]                 fwd_e_rt;
    logic [1:0]                 fwd_m_rt;

    modport master (
        output id_raddr0, id_raddr1, id_waddr, id_tuse0, id_tuse1, id_tnew,
        output id_uses_md, e_md_start, e_md_div, flush,
        input  stall, fwd_id_rs, fwd_id_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
    );

    modport slave (
        input  id_raddr0, id_raddr1, id_waddr, id_tuse0, id_tuse1, id_tnew,
        input  id_uses_md, e_md_start, e_md_div, flush,
        output stall, fwd_id_rs, fwd_id_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
    );

endinterface

// File: rtl/hazard_unit_md_busy_cnt.sv
// HI/LO busy window: counts down the multiply/divide latency once the op issues in E;
// busy is also raised combinationally in the issue cycle itself.
module md_busy_cnt
    import hazard_unit_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt != '0) | start;

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: Tnew scoreboard for E/M/W, ID stall decision, forward selects for the
// ID/E/M readers and the HI/LO multiply/divide interlock.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int TW       = TW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    typedef logic [TW-1:0] tcnt_t;

    reg_addr_t waddr_e_p0, rs_e_p0, rt_e_p0;
    tcnt_t     tnew_e_p0;
    reg_addr_t waddr_m_p1, rt_m_p1;
    tcnt_t     tnew_m_p1;
    reg_addr_t waddr_w_p2;
    tcnt_t     tnew_w_p2;

    logic      md_busy;
    logic      dep_stall;
    logic      stall_c;
    logic      squash_e;
    fwd_sel_e  sel_id_rs, sel_id_rt, sel_e_rs, sel_e_rt, sel_m_rt;

    function automatic tcnt_t tnew_dec(tcnt_t t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Only the nearest producer of a register matters; older copies are stale.
    function automatic logic src_stall(reg_addr_t a, tcnt_t tuse,
                                       reg_addr_t w_e, tcnt_t t_e,
                                       reg_addr_t w_m, tcnt_t t_m,
                                       reg_addr_t w_w, tcnt_t t_w);
        if (a == '0 || tuse == TW'(TUSE_NONE)) return 1'b0;
        if (a == w_e) return t_e > tuse;
        if (a == w_m) return t_m > tuse;
        if (a == w_w) return t_w > tuse;
        return 1'b0;
    endfunction

    function automatic fwd_sel_e pick_fwd(reg_addr_t a, logic see_e, logic see_m,
                                          reg_addr_t w_e, tcnt_t t_e,
                                          reg_addr_t w_m, tcnt_t t_m,
                                          reg_addr_t w_w, tcnt_t t_w);
        if (a == '0) return FWD_RF;
        if (see_e && a == w_e) return (t_e == '0) ? FWD_E : FWD_RF;
        if (see_m && a == w_m) return (t_m == '0) ? FWD_M : FWD_RF;
        if (a == w_w) return (t_w == '0) ? FWD_W : FWD_RF;
        return FWD_RF;
    endfunction

    md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy (
        .clk    (clk),
        .reset  (reset),
        .start  (hz.e_md_start),
        .is_div (hz.e_md_div),
        .busy   (md_busy)
    );

    always_comb begin
        dep_stall = src_stall(hz.id_raddr0, hz.id_tuse0,
                              waddr_e_p0, tnew_e_p0, waddr_m_p1, tnew_m_p1,
                              waddr_w_p2, tnew_w_p2)
                  | src_stall(hz.id_raddr1, hz.id_tuse1,
                              waddr_e_p0, tnew_e_p0, waddr_m_p1, tnew_m_p1,
                              waddr_w_p2, tnew_w_p2);
        stall_c   = dep_stall | (hz.id_uses_md & md_busy);
    end

    // A squashed or stalled ID slot enters E as an all-zero bubble.
    assign squash_e = stall_c | hz.flush;

    always_comb begin
        sel_id_rs = pick_fwd(hz.id_raddr0, 1'b1, 1'b1, waddr_e_p0, tnew_e_p0,
                             waddr_m_p1, tnew_m_p1, waddr_w_p2, tnew_w_p2);
        sel_id_rt = pick_fwd(hz.id_raddr1, 1'b1, 1'b1, waddr_e_p0, tnew_e_p0,
                             waddr_m_p1, tnew_m_p1, waddr_w_p2, tnew_w_p2);
        sel_e_rs  = pick_fwd(rs_e_p0, 1'b0, 1'b1, waddr_e_p0, tnew_e_p0,
                             waddr_m_p1, tnew_m_p1, waddr_w_p2, tnew_w_p2);
        sel_e_rt  = pick_fwd(rt_e_p0, 1'b0, 1'b1, waddr_e_p0, tnew_e_p0,
                             waddr_m_p1, tnew_m_p1, waddr_w_p2, tnew_w_p2);
        sel_m_rt  = pick_fwd(rt_m_p1, 1'b0, 1'b0, waddr_e_p0, tnew_e_p0,
                             waddr_m_p1, tnew_m_p1, waddr_w_p2, tnew_w_p2);
    end

    // ID -> E boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waddr_e_p0 <= '0;
            tnew_e_p0  <= '0;
            rs_e_p0    <= '0;
            rt_e_p0    <= '0;
        end else if (squash_e) begin
            waddr_e_p0 <= '0;
            tnew_e_p0  <= '0;
            rs_e_p0    <= '0;
            rt_e_p0    <= '0;
        end else begin
            waddr_e_p0 <= hz.id_waddr;
            tnew_e_p0  <= tnew_dec(hz.id_tnew);
            rs_e_p0    <= hz.id_raddr0;
            rt_e_p0    <= hz.id_raddr1;
        end
    end

    // E -> M and M -> W boundaries; flush leaves these stages alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waddr_m_p1 <= '0;
            tnew_m_p1  <= '0;
            rt_m_p1    <= '0;
            waddr_w_p2 <= '0;
            tnew_w_p2  <= '0;
        end else begin
            waddr_m_p1 <= waddr_e_p0;
            tnew_m_p1  <= tnew_dec(tnew_e_p0);
            rt_m_p1    <= rt_e_p0;
            waddr_w_p2 <= waddr_m_p1;
            tnew_w_p2  <= tnew_dec(tnew_m_p1);
        end
    end

    assign hz.stall     = stall_c;
    assign hz.fwd_id_rs = sel_id_rs;
    assign hz.fwd_id_rt = sel_id_rt;
    assign hz.fwd_e_rs  = sel_e_rs;
    assign hz.fwd_e_rt  = sel_e_rt;
    assign hz.fwd_m_rt  = sel_m_rt;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios plus randomized cycles checked against
// an absolute-time model of the in-flight instructions.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_if #(.TW(3)) hz();

    hazard_unit #(
        .MULT_CYC (MULT_N),
        .DIV_CYC  (DIV_N),
        .TW       (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Each in-flight instruction remembers the absolute cycle its result becomes available.
    typedef struct { bit v; int wa; int r0; int r1; int rdy; } ent_t;
    ent_t pipe [3];
    int   cyc    = 0;
    int   md_end = -1;

    function automatic int rem(ent_t e);
        return (e.v && e.rdy > cyc) ? e.rdy - cyc : 0;
    endfunction

    function automatic int nearest(int a, int from);
        if (a == 0) return -1;
        for (int s = from; s < 3; s++)
            if (pipe[s].v && pipe[s].wa == a) return s;
        return -1;
    endfunction

    function automatic int exp_fwd(int a, int from);
        int s;
        s = nearest(a, from);
        if (s < 0) return 0;
        return (rem(pipe[s]) == 0) ? s + 1 : 0;
    endfunction

    function automatic bit exp_stall();
        int a [2];
        int tu [2];
        int s;
        a[0]  = int'(hz.id_raddr0);
        a[1]  = int'(hz.id_raddr1);
        tu[0] = int'(hz.id_tuse0);
        tu[1] = int'(hz.id_tuse1);
        for (int k = 0; k < 2; k++) begin
            s = nearest(a[k], 0);
            if (s >= 0 && rem(pipe[s]) > tu[k]) return 1'b1;
        end
        return hz.id_uses_md && (hz.e_md_start || cyc <= md_end);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0, 0};
            md_end = -1;
        end else begin
            bit st;
            st = exp_stall();
            if (hz.e_md_start) md_end = cyc + (hz.e_md_div ? DIV_N : MULT_N);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st || hz.flush) pipe[0] = '{0, 0, 0, 0, 0};
            else pipe[0] = '{1, int'(hz.id_waddr), int'(hz.id_raddr0), int'(hz.id_raddr1),
                             cyc + int'(hz.id_tnew)};
            cyc++;
        end
    end

    task automatic put_id(input int r0, input int r1, input int tu0, input int tu1,
                          input int wa, input int tn);
        hz.id_raddr0 = 5'(r0);
        hz.id_raddr1 = 5'(r1);
        hz.id_tuse0  = 3'(tu0);
        hz.id_tuse1  = 3'(tu1);
        hz.id_waddr  = 5'(wa);
        hz.id_tnew   = 3'(tn);
    endtask

    task automatic nop();
        put_id(0, 0, 7, 7, 0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input int irs, input int irt,
                           input int ers, input int ert, input int mrt);
        chk({tag, "_stall"},     int'(hz.stall),     st);
        chk({tag, "_fwd_id_rs"}, int'(hz.fwd_id_rs), irs);
        chk({tag, "_fwd_id_rt"}, int'(hz.fwd_id_rt), irt);
        chk({tag, "_fwd_e_rs"},  int'(hz.fwd_e_rs),  ers);
        chk({tag, "_fwd_e_rt"},  int'(hz.fwd_e_rt),  ert);
        chk({tag, "_fwd_m_rt"},  int'(hz.fwd_m_rt),  mrt);
    endtask

    initial begin
        put_id(0, 0, 0, 0, 0, 0);
        hz.id_uses_md = 1'b0;
        hz.e_md_start = 1'b0;
        hz.e_md_div   = 1'b0;
        hz.flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // idle after reset, all inputs zero
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_all("reset_idle", 0, 0, 0, 0, 0, 0);
            adv();
        end

        // addu $3 then beq $3: one stall, then M forward
        put_id(0, 0, 7, 7, 3, 2);
        settle(); chk("addu_issue_stall", int'(hz.stall), 0);
        adv();
        put_id(3, 0, 0, 0, 0, 0);
        settle(); chk("beq_stall", int'(hz.stall), 1);
        adv();
        settle();
        chk("beq_release_stall", int'(hz.stall), 0);
        chk("beq_fwd_id_rs", int'(hz.fwd_id_rs), 2);
        adv();
        nop(); repeat (3) adv();

        // lw $5 then addu $6,$5,$5: one stall, then W forward into E
        put_id(0, 0, 7, 7, 5, 3);
        settle(); adv();
        put_id(5, 5, 1, 1, 6, 2);
        settle(); chk("lw_use_stall", int'(hz.stall), 1);
        adv();
        settle();
        chk("lw_use_release", int'(hz.stall), 0);
        chk("lw_use_fwd_id_rs", int'(hz.fwd_id_rs), 0);
        adv();
        nop();
        settle();
        chk("lw_use_fwd_e_rs", int'(hz.fwd_e_rs), 3);
        chk("lw_use_fwd_e_rt", int'(hz.fwd_e_rt), 3);
        adv();
        repeat (3) adv();

        // lui $7 then jr $7: E forward, no stall
        put_id(0, 0, 7, 7, 7, 1);
        settle(); adv();
        put_id(7, 0, 0, 7, 0, 0);
        settle();
        chk("jr_stall", int'(hz.stall), 0);
        chk("jr_fwd_id_rs", int'(hz.fwd_id_rs), 1);
        adv();
        nop(); repeat (3) adv();

        // div busy window with mflo waiting in ID, then mult
        hz.id_uses_md = 1'b1;
        hz.e_md_start = 1'b1;
        hz.e_md_div   = 1'b1;
        for (int i = 0; i < DIV_N + 2; i++) begin
            settle();
            chk($sformatf("div_busy_%0d", i), int'(hz.stall), (i < DIV_N + 1) ? 1 : 0);
            adv();
            hz.e_md_start = 1'b0;
        end
        hz.e_md_start = 1'b1;
        hz.e_md_div   = 1'b0;
        for (int i = 0; i < MULT_N + 2; i++) begin
            settle();
            chk($sformatf("mult_busy_%0d", i), int'(hz.stall), (i < MULT_N + 1) ? 1 : 0);
            adv();
            hz.e_md_start = 1'b0;
        end
        hz.id_uses_md = 1'b0;

        // flush in a stall cycle: E must take a bubble, not the ID reader of $9
        put_id(0, 0, 7, 7, 9, 1);
        settle(); adv();
        put_id(9, 9, 1, 1, 10, 2);
        hz.id_uses_md = 1'b1;
        hz.e_md_start = 1'b1;
        hz.e_md_div   = 1'b0;
        hz.flush      = 1'b1;
        settle();
        chk("flush_cyc_stall", int'(hz.stall), 1);
        chk("flush_cyc_fwd_id_rs", int'(hz.fwd_id_rs), 1);
        adv();
        hz.flush      = 1'b0;
        hz.e_md_start = 1'b0;
        hz.id_uses_md = 1'b0;
        nop();
        settle();
        chk_all("after_flush", 0, 0, 0, 0, 0, 0);
        adv();
        repeat (MULT_N + 1) adv();

        // reset dropped mid-divide clears busy without waiting for a clock
        hz.id_uses_md = 1'b1;
        hz.e_md_start = 1'b1;
        hz.e_md_div   = 1'b1;
        settle(); adv();
        hz.e_md_start = 1'b0;
        adv(); adv();
        settle();
        chk("mid_div_busy", int'(hz.stall), 1);
        reset = 1'b0;
        #1;
        chk("mid_div_reset_busy", int'(hz.stall), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        hz.id_uses_md = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            put_id($urandom_range(0, 7), $urandom_range(0, 7),
                   ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3),
                   $urandom_range(0, 7), $urandom_range(0, 5));
            hz.id_uses_md = ($urandom_range(0, 3) == 0);
            hz.e_md_start = ($urandom_range(0, 9) == 0);
            hz.e_md_div   = $urandom_range(0, 1) == 1;
            hz.flush      = ($urandom_range(0, 15) == 0);
            settle();
            chk("rnd_stall",     int'(hz.stall),     int'(exp_stall()));
            chk("rnd_fwd_id_rs", int'(hz.fwd_id_rs), exp_fwd(int'(hz.id_raddr0), 0));
            chk("rnd_fwd_id_rt", int'(hz.fwd_id_rt), exp_fwd(int'(hz.id_raddr1), 0));
            chk("rnd_fwd_e_rs",  int'(hz.fwd_e_rs),  exp_fwd(pipe[0].r0, 1));
            chk("rnd_fwd_e_rt",  int'(hz.fwd_e_rt),  exp_fwd(pipe[0].r1, 1));
            chk("rnd_fwd_m_rt",  int'(hz.fwd_m_rt),  exp_fwd(pipe[1].r1, 2));
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
